// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset / clock-enable generator.
//   state_t     : reset sequencer states
//   cpu_divisor : CPU clock-enable divisor for a given rate select
//   max3        : largest of three values, used to size the sequencer counter
package pll_reset_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    HOLD,
    STAGGER,
    RUN
  } state_t;

  function automatic int unsigned cpu_divisor(input int unsigned base, input logic [1:0] sel);
    return base >> sel;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_ce_gen_ce_divider.sv
// Single-cycle clock-enable divider.
//   clk, rst_n : system clock, asynchronous active-low reset
//   clear      : holds the counter at 0 and ce low; div is loaded while clear is high
//   div        : divisor (clk cycles per ce pulse), sampled on clear and at each wrap only
//   ce         : registered one-cycle enable, high once every div cycles
module ce_divider #(
  parameter int unsigned DIV_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [DIV_W:0]   div,
  output logic             ce
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  // The terminal count is latched rather than decoded live from div, so a
  // divisor change mid-period only takes effect from the next period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      last <= '0;
      ce   <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      last <= DIV_W'(div - 1'b1);
      ce   <= 1'b0;
    end else if (cnt == last) begin
      cnt  <= '0;
      last <= DIV_W'(div - 1'b1);
      ce   <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      ce   <= 1'b0;
    end
  end

endmodule

// File: rtl/pll_reset_ce_gen.sv
// Reset sequencer and clock-enable generator downstream of the system PLL.
//   clk            : 50 MHz system clock
//   rst_n          : asynchronous active-low reset
//   pll_locked     : PLL lock flag, asynchronous, 2-FF synchronised internally
//   soft_reset_req : level request to rerun the reset hold (honoured in HOLD/STAGGER/RUN)
//   cpu_div_sel    : CPU enable divisor = CPU_DIV_BASE >> cpu_div_sel
//   sys_reset      : active-high reset for video/peripherals
//   cpu_reset      : active-high reset for the CPU, released CPU_STAGGER cycles after sys_reset
//   cpu_ce, pix_ce : one-cycle clock enables
//   ready          : high while in RUN
module pll_reset_ce_gen
  import pll_reset_pkg::*;
#(
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned RESET_HOLD   = 256,
  parameter int unsigned CPU_STAGGER  = 16,
  parameter int unsigned CPU_DIV_BASE = 50,
  parameter int unsigned PIX_DIV      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  input  logic [1:0] cpu_div_sel,
  output logic       sys_reset,
  output logic       cpu_reset,
  output logic       cpu_ce,
  output logic       pix_ce,
  output logic       ready
);

  localparam int unsigned CNT_W = $clog2(max3(LOCK_STABLE, RESET_HOLD, CPU_STAGGER) + 1);
  localparam int unsigned CPU_W = $clog2(CPU_DIV_BASE);
  localparam int unsigned PIX_W = $clog2(PIX_DIV + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(CPU_STAGGER - 1);
  localparam logic [PIX_W:0]   PIX_DIV_VAL  = (PIX_W + 1)'(PIX_DIV);

  logic             lk_meta;
  logic             lk_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CPU_W:0]   cpu_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Priority: lock loss, then soft reset, then counter expiry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    unique case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lk_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lk_s)                  state_nxt = WAIT_LOCK;
        else if (cnt == LOCK_LAST)  state_nxt = HOLD;
      end
      HOLD: begin
        if (!lk_s)                  state_nxt = WAIT_LOCK;
        else if (soft_reset_req)    cnt_nxt   = '0;
        else if (cnt == HOLD_LAST)  state_nxt = STAGGER;
      end
      STAGGER: begin
        if (!lk_s)                     state_nxt = WAIT_LOCK;
        else if (soft_reset_req)       state_nxt = HOLD;
        else if (cnt == STAGGER_LAST)  state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lk_s)                state_nxt = WAIT_LOCK;
        else if (soft_reset_req)  state_nxt = HOLD;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state they belong to while still coming straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_reset <= 1'b1;
      cpu_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      sys_reset <= (state_nxt == WAIT_LOCK) || (state_nxt == STABLE) || (state_nxt == HOLD);
      cpu_reset <= (state_nxt != RUN);
      ready     <= (state_nxt == RUN);
    end
  end

  assign cpu_div = (CPU_W + 1)'(cpu_divisor(CPU_DIV_BASE, cpu_div_sel));

  ce_divider #(
    .DIV_W (CPU_W)
  ) u_cpu_ce (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cpu_reset),
    .div   (cpu_div),
    .ce    (cpu_ce)
  );

  ce_divider #(
    .DIV_W (PIX_W)
  ) u_pix_ce (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (~lk_s),
    .div   (PIX_DIV_VAL),
    .ce    (pix_ce)
  );

endmodule
